// File: rtl/design_06_pkg.sv
// Shared definitions for the design_06 registered adder.
// The default width lives here. The {carry, sum} result layout also lives here, at the
// default width; design_06 redeclares the same layout at its own parameter width W.
package design_06_pkg;

    localparam int unsigned DESIGN_06_W_DEFAULT = 10;

    // Adder result: carry-out above the modulo-2^W sum.
    typedef struct packed {
        logic                           carry;
        logic [DESIGN_06_W_DEFAULT-1:0] sum;
    } add_res_t;

endpackage

// File: rtl/design_06_add.sv
// Combinational W-bit unsigned adder producing the modulo-2^W sum and the carry-out.
module design_06_add
    import design_06_pkg::*;
#(
    parameter int unsigned W = DESIGN_06_W_DEFAULT
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] sum,
    output logic         carry
);

    // Widen by one bit so the carry falls out of the top of the addition.
    assign {carry, sum} = {1'b0, a} + {1'b0, b};

endmodule

// File: rtl/design_06.sv
// Registered adder with a start/valid strobe handshake.
// A start edge captures a + b into y. valid pulses for one cycle on the following cycle.
// Optional feature: define DESIGN_06_OVF_EN to add the registered carry-out port ovf.
module design_06
    import design_06_pkg::*;
#(
    parameter int unsigned W = DESIGN_06_W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] y,
`ifdef DESIGN_06_OVF_EN
    output logic         valid,
    output logic         ovf
`else
    output logic         valid
`endif
);

    typedef struct packed {
        logic         carry;
        logic [W-1:0] sum;
    } res_t;

    res_t         add_res;
    logic [W-1:0] y_q, y_d;
    logic         valid_q, valid_d;

    design_06_add #(
        .W (W)
    ) u_add (
        .a     (a),
        .b     (b),
        .sum   (add_res.sum),
        .carry (add_res.carry)
    );

`ifdef DESIGN_06_OVF_EN
    logic ovf_q, ovf_d;
`else
    logic unused_carry;
    assign unused_carry = add_res.carry;
`endif

    // Next state: capture on start; otherwise hold the result. valid simply follows start.
    always_comb begin
        y_d     = y_q;
        valid_d = start;
`ifdef DESIGN_06_OVF_EN
        ovf_d   = ovf_q;
`endif
        if (start) begin
            y_d   = add_res.sum;
`ifdef DESIGN_06_OVF_EN
            ovf_d = add_res.carry;
`endif
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            y_q     <= '0;
            valid_q <= 1'b0;
`ifdef DESIGN_06_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            y_q     <= y_d;
            valid_q <= valid_d;
`ifdef DESIGN_06_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign y     = y_q;
    assign valid = valid_q;
`ifdef DESIGN_06_OVF_EN
    assign ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_design_06.sv
// Self-checking bench for design_06: expected results are queued as stimulus is driven and
// popped for comparison one cycle later, after the capturing edge.
module tb_design_06;

    localparam int unsigned W = 10;

    logic         clk;
    logic         rst_n;
    logic         start;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] y;
    logic         valid;
`ifdef DESIGN_06_OVF_EN
    logic         ovf;
`endif

    design_06 #(
        .W (W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .y     (y),
`ifdef DESIGN_06_OVF_EN
        .valid (valid),
        .ovf   (ovf)
`else
        .valid (valid)
`endif
    );

    typedef struct packed {
        logic         v;
        logic [W-1:0] y;
        logic         o;
    } exp_t;

    exp_t         sb[$];
    int           n_chk = 0;
    int           n_bad = 0;
    logic [W-1:0] m_y   = '0;
    logic         m_ovf = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value against the expected one.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    // Compare every output against the idle/reset state (zero sum, no valid).
    task automatic check_zero(input string tag);
        check({tag, ".valid"}, {31'd0, valid}, 32'd0);
        check({tag, ".y"}, {{(32 - W){1'b0}}, y}, 32'd0);
`ifdef DESIGN_06_OVF_EN
        check({tag, ".ovf"}, {31'd0, ovf}, 32'd0);
`endif
    endtask

    // Drive one cycle of stimulus, queue its expected outcome, then pop and compare after the edge.
    task automatic step(input string tag, input logic st, input logic [W-1:0] x,
                        input logic [W-1:0] z);
        logic [W:0] s;
        exp_t       e;
        start = st;
        a     = x;
        b     = z;
        s     = {1'b0, x} + {1'b0, z};
        if (st) begin
            m_y   = s[W-1:0];
            m_ovf = s[W];
        end
        e.v = st;
        e.y = m_y;
        e.o = m_ovf;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check({tag, ".sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            check({tag, ".valid"}, {31'd0, valid}, {31'd0, e.v});
            check({tag, ".y"}, {{(32 - W){1'b0}}, y}, {{(32 - W){1'b0}}, e.y});
`ifdef DESIGN_06_OVF_EN
            check({tag, ".ovf"}, {31'd0, ovf}, {31'd0, e.o});
`endif
        end
    endtask

    // Watchdog so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1;
        check_zero("rst_async");

        // Reset held for three cycles while start toggles.
        for (int i = 0; i < 3; i++) begin
            start = ~start;
            a     = W'($urandom);
            b     = W'($urandom);
            @(posedge clk);
            #1;
            check_zero("rst_hold");
        end
        start = 1'b0;
        rst_n = 1'b1;

        step("idle", 1'b0, 10'd5, 10'd6);
        step("basic", 1'b1, 10'd3, 10'd5);
        step("basic_after", 1'b0, 10'd3, 10'd5);
        step("hold", 1'b0, 10'd7, 10'd9);
        step("wrap", 1'b1, 10'd1023, 10'd1);
        step("wrap_after", 1'b0, 10'd0, 10'd0);
        step("b2b_0", 1'b1, 10'd10, 10'd20);
        step("b2b_1", 1'b1, 10'd100, 10'd200);
        step("b2b_end", 1'b0, 10'd1, 10'd1);

        for (int i = 0; i < 24; i++) begin
            step("rand", 1'($urandom), W'($urandom), W'($urandom));
        end
        step("pre_midop", 1'b1, 10'd600, 10'd500);

        // Start is pending, then reset lands before the capturing edge.
        start = 1'b1;
        a     = 10'd4;
        b     = 10'd4;
        #2;
        rst_n = 1'b0;
        #1;
        check_zero("midop_async");
        @(posedge clk);
        #1;
        check_zero("midop_edge");
        start = 1'b0;
        rst_n = 1'b1;
        m_y   = '0;
        m_ovf = 1'b0;

        step("post_idle", 1'b0, 10'd9, 10'd9);
        step("post_start", 1'b1, 10'd2, 10'd2);
        step("post_after", 1'b0, 10'd0, 10'd0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
